// File: rtl/int_arbiter_if.sv
// rtl/int_arbiter_if.sv - interrupt arbiter request/response bundle between pins, plaFSM and arbiter
interface int_arbiter_if #(
  parameter int NUM_IRQ = 4,
  parameter int IDX_W   = 3
);
  logic               RDY;
  logic               nmi;
  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irq_en;
  logic [7:0]         statusReg;
  logic               brk;
  logic               T1now;
  logic               int_done;
  logic [2:0]         active_interrupt;
  logic [15:0]        vector;
  logic [IDX_W-1:0]   irq_src;
  logic               pending;
  logic               busy;

  modport master (
    output RDY, nmi, irq, irq_en, statusReg, brk, T1now, int_done,
    input  active_interrupt, vector, irq_src, pending, busy
  );

  modport slave (
    input  RDY, nmi, irq, irq_en, statusReg, brk, T1now, int_done,
    output active_interrupt, vector, irq_src, pending, busy
  );
endinterface

// File: rtl/int_arbiter.sv
// rtl/int_arbiter.sv - fixed-priority RST/NMI/IRQ/BRK front-end for plaFSM
// Optional INT_VECTOR_TABLE_EN gives each IRQ channel its own vector.
module int_arbiter #(
  parameter int NUM_IRQ     = 4,
  parameter int IDX_W       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic          phi1,
  input  logic          rst,
  int_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    INT_NONE = 3'd0,
    INT_RST  = 3'd1,
    INT_NMI  = 3'd2,
    INT_IRQ  = 3'd3,
    INT_BRK  = 3'd4
  } int_code_e;

  typedef enum logic {S_IDLE, S_ACTIVE} state_e;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RST = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  state_e             state;
  int_code_e          active_q;
  logic [15:0]        vector_q;
  logic [IDX_W-1:0]   src_q;
  logic               busy_q;

  logic [SYNC_STAGES-1:0] nmi_sq;
  logic [NUM_IRQ-1:0]     irq_sq [SYNC_STAGES];
  logic                   nmi_prev;
  logic                   nmi_pend;
  logic                   rst_pend;

  logic               nmi_s;
  logic               nmi_edge;
  logic [NUM_IRQ-1:0] req;
  logic               req_any;
  logic [IDX_W-1:0]   req_idx;
  logic [15:0]        irq_vec;
  logic               arb;
  logic               status_unused;

  assign nmi_s    = nmi_sq[SYNC_STAGES-1];
  assign nmi_edge = nmi_s & ~nmi_prev;
  assign req      = irq_sq[SYNC_STAGES-1] & bus.irq_en & {NUM_IRQ{~bus.statusReg[2]}};
  assign req_any  = |req;
  assign arb      = bus.T1now & bus.RDY & ~busy_q;
  assign status_unused = ^{bus.statusReg[7:3], bus.statusReg[1:0]};

  // Lowest index wins, so scan downwards and let the last hit stick.
  always_comb begin
    req_idx = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (req[k]) req_idx = IDX_W'(k);
    end
  end

`ifdef INT_VECTOR_TABLE_EN
  assign irq_vec = VEC_IRQ - ((16'(req_idx) + 16'd1) << 5);
`else
  assign irq_vec = VEC_IRQ;
`endif

  always_ff @(posedge phi1 or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      active_q <= INT_NONE;
      vector_q <= VEC_RST;
      src_q    <= '0;
      busy_q   <= 1'b0;
      nmi_sq   <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) irq_sq[s] <= '0;
      nmi_prev <= 1'b0;
      nmi_pend <= 1'b0;
      rst_pend <= 1'b1;
    end else begin
      nmi_sq[0] <= bus.nmi;
      irq_sq[0] <= bus.irq;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        nmi_sq[s] <= nmi_sq[s-1];
        irq_sq[s] <= irq_sq[s-1];
      end
      nmi_prev <= nmi_s;

      case (state)
        S_IDLE: begin
          if (arb && (rst_pend || nmi_pend || req_any || bus.brk)) begin
            state  <= S_ACTIVE;
            busy_q <= 1'b1;
            if (rst_pend) begin
              active_q <= INT_RST;
              vector_q <= VEC_RST;
              rst_pend <= 1'b0;
            end else if (nmi_pend) begin
              active_q <= INT_NMI;
              vector_q <= VEC_NMI;
              nmi_pend <= 1'b0;
            end else if (req_any) begin
              active_q <= INT_IRQ;
              vector_q <= irq_vec;
              src_q    <= req_idx;
            end else begin
              active_q <= INT_BRK;
              vector_q <= VEC_IRQ;
            end
          end
        end
        S_ACTIVE: begin
          if (bus.int_done && bus.RDY) begin
            state    <= S_IDLE;
            active_q <= INT_NONE;
            vector_q <= VEC_RST;
            busy_q   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      // A fresh edge outranks the clear of an NMI being taken this cycle.
      if (nmi_edge) nmi_pend <= 1'b1;
    end
  end

  assign bus.active_interrupt = active_q;
  assign bus.vector           = vector_q;
  assign bus.irq_src          = src_q;
  assign bus.busy             = busy_q;
  assign bus.pending          = rst_pend | nmi_pend | req_any;

endmodule

// File: tb/tb_int_arbiter.sv
// tb/tb_int_arbiter.sv - randomized and directed bench for int_arbiter against a behavioural model
module tb_int_arbiter;
  localparam int NI = 4;
  localparam int IW = 3;
  localparam int SS = 2;

  logic phi1 = 1'b0;
  logic rst  = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  int_arbiter_if #(.NUM_IRQ(NI), .IDX_W(IW)) bus ();

  int_arbiter #(.NUM_IRQ(NI), .IDX_W(IW), .SYNC_STAGES(SS)) dut (
    .phi1 (phi1),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 phi1 = ~phi1;

  // Reference model: pin histories stand in for the synchronisers.
  int          m_code;
  logic [15:0] m_vec;
  int          m_src;
  bit          m_rst_pend, m_nmi_pend;
  logic        nmi_hist[$];
  logic [NI-1:0] irq_hist[$];

  function automatic logic [15:0] exp_irq_vec(int src);
`ifdef INT_VECTOR_TABLE_EN
    return 16'hFFFE - 16'h0020 * 16'(src + 1);
`else
    return 16'hFFFE;
`endif
  endfunction

  function automatic logic [NI-1:0] model_req();
    return irq_hist[SS-1] & bus.irq_en & {NI{~bus.statusReg[2]}};
  endfunction

  function automatic bit model_pending();
    return m_rst_pend || m_nmi_pend || (model_req() != 0);
  endfunction

  task automatic model_reset();
    m_code = 0; m_vec = 16'hFFFC; m_src = 0;
    m_rst_pend = 1; m_nmi_pend = 0;
    nmi_hist.delete(); irq_hist.delete();
    for (int i = 0; i <= SS; i++) begin
      nmi_hist.push_back(1'b0);
      irq_hist.push_back('0);
    end
  endtask

  task automatic model_edge();
    logic [NI-1:0] rq;
    bit edge_seen;
    if (!rst) begin
      model_reset();
      return;
    end
    rq = model_req();
    edge_seen = nmi_hist[SS-1] && !nmi_hist[SS];
    if (m_code != 0) begin
      if (bus.int_done && bus.RDY) begin m_code = 0; m_vec = 16'hFFFC; end
    end else if (bus.T1now && bus.RDY) begin
      if (m_rst_pend) begin
        m_code = 1; m_vec = 16'hFFFC; m_rst_pend = 0;
      end else if (m_nmi_pend) begin
        m_code = 2; m_vec = 16'hFFFA; m_nmi_pend = 0;
      end else if (rq != 0) begin
        m_code = 3;
        for (int i = NI - 1; i >= 0; i--) if (rq[i]) m_src = i;
        m_vec = exp_irq_vec(m_src);
      end else if (bus.brk) begin
        m_code = 4; m_vec = 16'hFFFE;
      end
    end
    if (edge_seen) m_nmi_pend = 1;
    nmi_hist.push_front(bus.nmi); void'(nmi_hist.pop_back());
    irq_hist.push_front(bus.irq); void'(irq_hist.pop_back());
  endtask

  task automatic tick();
    @(posedge phi1);
    model_edge();
    #1;
  endtask

  task automatic idle(int n);
    bus.T1now = 0; bus.int_done = 0; bus.brk = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 0;
    model_reset();
    tick(); tick();
    vectors++; if (bus.active_interrupt !== 3'd0) begin miscompares++; $display("FAIL reset_code got %0d want 0", bus.active_interrupt); end
    vectors++; if (bus.vector !== 16'hFFFC) begin miscompares++; $display("FAIL reset_vector got %h want fffc", bus.vector); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.irq_src !== 3'd0) begin miscompares++; $display("FAIL reset_src got %0d want 0", bus.irq_src); end
    vectors++; if (bus.pending !== 1'b1) begin miscompares++; $display("FAIL reset_pending got %b want 1", bus.pending); end
    rst = 1;
    idle(1);
  endtask

  task automatic test_rst_request();
    bus.T1now = 1; tick(); bus.T1now = 0;
    vectors++; if (bus.active_interrupt !== 3'd1) begin miscompares++; $display("FAIL rstreq_code got %0d want 1", bus.active_interrupt); end
    vectors++; if (bus.vector !== 16'hFFFC) begin miscompares++; $display("FAIL rstreq_vector got %h want fffc", bus.vector); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL rstreq_busy got %b want 1", bus.busy); end
    bus.int_done = 1; tick(); bus.int_done = 0;
    vectors++; if (bus.active_interrupt !== 3'd0) begin miscompares++; $display("FAIL rstdone_code got %0d want 0", bus.active_interrupt); end
    vectors++; if (bus.pending !== 1'b0) begin miscompares++; $display("FAIL rstdone_pending got %b want 0", bus.pending); end
  endtask

  task automatic test_nmi_held();
    bus.nmi = 1;
    idle(10);
    bus.T1now = 1; tick(); bus.T1now = 0;
    vectors++; if (bus.active_interrupt !== 3'd2) begin miscompares++; $display("FAIL nmi_code got %0d want 2", bus.active_interrupt); end
    vectors++; if (bus.vector !== 16'hFFFA) begin miscompares++; $display("FAIL nmi_vector got %h want fffa", bus.vector); end
    bus.int_done = 1; tick(); bus.int_done = 0;
    bus.T1now = 1; tick(); bus.T1now = 0;
    vectors++; if (bus.active_interrupt !== 3'd0) begin miscompares++; $display("FAIL nmi_once got %0d want 0", bus.active_interrupt); end
    bus.nmi = 0;
    idle(4);
  endtask

  task automatic test_irq_mask();
    bus.irq = 4'b1010; bus.irq_en = 4'b1111; bus.statusReg = 8'h00;
    idle(SS + 1);
    bus.T1now = 1; tick(); bus.T1now = 0;
    vectors++; if (bus.active_interrupt !== 3'd3) begin miscompares++; $display("FAIL irq_code got %0d want 3", bus.active_interrupt); end
    vectors++; if (bus.irq_src !== 3'd1) begin miscompares++; $display("FAIL irq_src got %0d want 1", bus.irq_src); end
    vectors++; if (bus.vector !== exp_irq_vec(1)) begin miscompares++; $display("FAIL irq_vector got %h want %h", bus.vector, exp_irq_vec(1)); end
    bus.int_done = 1; tick(); bus.int_done = 0;
    bus.statusReg = 8'h04;
    bus.T1now = 1; tick(); bus.T1now = 0;
    vectors++; if (bus.active_interrupt !== 3'd0) begin miscompares++; $display("FAIL irq_masked got %0d want 0", bus.active_interrupt); end
    vectors++; if (bus.pending !== 1'b0) begin miscompares++; $display("FAIL irq_masked_pending got %b want 0", bus.pending); end
    bus.irq = 0; bus.statusReg = 8'h00;
    idle(SS + 1);
  endtask

  task automatic test_priority();
    bus.nmi = 1; bus.irq = 4'b0001; bus.irq_en = 4'b1111;
    idle(SS + 2);
    bus.brk = 1; bus.T1now = 1; tick(); bus.brk = 0; bus.T1now = 0;
    vectors++; if (bus.active_interrupt !== 3'd2) begin miscompares++; $display("FAIL prio_nmi got %0d want 2", bus.active_interrupt); end
    bus.int_done = 1; tick(); bus.int_done = 0;
    bus.brk = 1; bus.T1now = 1; tick(); bus.brk = 0; bus.T1now = 0;
    vectors++; if (bus.active_interrupt !== 3'd3) begin miscompares++; $display("FAIL prio_irq got %0d want 3", bus.active_interrupt); end
    vectors++; if (bus.irq_src !== 3'd0) begin miscompares++; $display("FAIL prio_src got %0d want 0", bus.irq_src); end
    bus.int_done = 1; tick(); bus.int_done = 0;
    bus.irq = 0; bus.nmi = 0;
    idle(SS + 1);
    bus.brk = 1; bus.T1now = 1; tick(); bus.brk = 0; bus.T1now = 0;
    vectors++; if (bus.active_interrupt !== 3'd4) begin miscompares++; $display("FAIL prio_brk got %0d want 4", bus.active_interrupt); end
    vectors++; if (bus.vector !== 16'hFFFE) begin miscompares++; $display("FAIL brk_vector got %h want fffe", bus.vector); end
    bus.int_done = 1; tick(); bus.int_done = 0;
  endtask

  task automatic test_rdy();
    bus.irq = 4'b0100; bus.irq_en = 4'b1111;
    idle(SS + 1);
    bus.RDY = 0; bus.T1now = 1; tick();
    vectors++; if (bus.active_interrupt !== 3'd0) begin miscompares++; $display("FAIL rdy_hold_arb got %0d want 0", bus.active_interrupt); end
    bus.RDY = 1; tick(); bus.T1now = 0;
    vectors++; if (bus.irq_src !== 3'd2 || bus.active_interrupt !== 3'd3) begin miscompares++; $display("FAIL rdy_arb got code %0d src %0d want 3/2", bus.active_interrupt, bus.irq_src); end
    bus.RDY = 0; bus.int_done = 1; tick();
    vectors++; if (bus.active_interrupt !== 3'd3) begin miscompares++; $display("FAIL rdy_hold_done got %0d want 3", bus.active_interrupt); end
    bus.RDY = 1; tick(); bus.int_done = 0;
    vectors++; if (bus.active_interrupt !== 3'd0) begin miscompares++; $display("FAIL rdy_done got %0d want 0", bus.active_interrupt); end
    bus.T1now = 1; tick();
    bus.int_done = 1; tick(); bus.int_done = 0; bus.T1now = 0;
    vectors++; if (bus.active_interrupt !== 3'd0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL done_t1_same got %0d busy %b want 0/0", bus.active_interrupt, bus.busy); end
    bus.irq = 0;
    idle(SS + 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      bus.RDY      = ($urandom_range(0, 4) != 0);
      bus.T1now    = ($urandom_range(0, 3) == 0);
      bus.int_done = ($urandom_range(0, 3) == 0);
      bus.brk      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) bus.nmi = ~bus.nmi;
      if ($urandom_range(0, 3) == 0) bus.irq = NI'($urandom);
      if ($urandom_range(0, 7) == 0) bus.irq_en = NI'($urandom);
      if ($urandom_range(0, 7) == 0) bus.statusReg = 8'($urandom);
      tick();
      vectors++; if (bus.active_interrupt !== 3'(m_code)) begin miscompares++; $display("FAIL rand_code n=%0d got %0d want %0d", n, bus.active_interrupt, m_code); end
      vectors++; if (bus.vector !== m_vec) begin miscompares++; $display("FAIL rand_vector n=%0d got %h want %h", n, bus.vector, m_vec); end
      vectors++; if (bus.busy !== (m_code != 0)) begin miscompares++; $display("FAIL rand_busy n=%0d got %b want %b", n, bus.busy, m_code != 0); end
      vectors++; if (bus.pending !== model_pending()) begin miscompares++; $display("FAIL rand_pending n=%0d got %b want %b", n, bus.pending, model_pending()); end
      if (m_code == 3) begin
        vectors++; if (bus.irq_src !== 3'(m_src)) begin miscompares++; $display("FAIL rand_src n=%0d got %0d want %0d", n, bus.irq_src, m_src); end
      end
    end
    bus.nmi = 0; bus.irq = 0; bus.RDY = 1;
    idle(SS + 2);
  endtask

  task automatic test_reset_midactive();
    rst = 0; idle(1); rst = 1; idle(1);
    bus.T1now = 1; tick(); bus.T1now = 0;
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL mid_pre_busy got %b want 1", bus.busy); end
    #2 rst = 0;
    model_reset();
    #1;
    vectors++; if (bus.active_interrupt !== 3'd0 || bus.vector !== 16'hFFFC || bus.busy !== 1'b0) begin miscompares++; $display("FAIL mid_reset got code %0d vec %h busy %b want 0/fffc/0", bus.active_interrupt, bus.vector, bus.busy); end
    vectors++; if (bus.pending !== 1'b1) begin miscompares++; $display("FAIL mid_reset_pending got %b want 1", bus.pending); end
    idle(1); rst = 1; idle(1);
  endtask

  initial begin
    bus.RDY = 1; bus.nmi = 0; bus.irq = 0; bus.irq_en = 0; bus.statusReg = 0;
    bus.brk = 0; bus.T1now = 0; bus.int_done = 0;
    model_reset();
    test_reset();
    test_rst_request();
    test_nmi_held();
    test_irq_mask();
    test_priority();
    test_rdy();
    test_random();
    test_reset_midactive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/int_arbiter.md
Name: int_arbiter

Overview:
- Parametrised interrupt front-end for the 6502C core.
- Sits between the external interrupt pins and plaFSM. Replaces the single-IRQ/NMI handling with:
  - N maskable IRQ channels,
  - NMI edge capture,
  - post-reset RST request,
  - BRK, under fixed priority.
- Presents one latched interrupt code and vector to the FSM and holds it until the FSM signals vector-fetch completion.

Parameters:
- NUM_IRQ, 4, number of maskable IRQ channels (1..8).
- IDX_W, 3, width of the channel index output; must satisfy 2^IDX_W >= NUM_IRQ.
- SYNC_STAGES, 2, synchroniser flops on nmi and irq inputs (1..3).

Ports:
- phi1  in  1  core clock; all state updates on posedge phi1.
- rst  in  1  asynchronous, active-low reset.
- RDY  in  1  CPU ready; when low, no arbitration or clear occurs that cycle.
- nmi  in  1  non-maskable interrupt, active-high, asynchronous.
- irq  in  NUM_IRQ  level interrupt requests, active-high, asynchronous.
- irq_en  in  NUM_IRQ  per-channel enable mask.
- statusReg  in  8  processor status; bit 2 = I (IRQ disable).
- brk  in  1  single-cycle pulse from the FSM when opcode 0x00 is decoded.
- T1now  in  1  FSM arbitration point (last cycle of the current instruction).
- int_done  in  1  single-cycle pulse after the FSM has fetched the vector high byte.
- active_interrupt  out  3  NONE=0, RST=1, NMI=2, IRQ=3, BRK=4.
- vector  out  16  vector address for active_interrupt.
- irq_src  out  IDX_W  winning IRQ channel (valid when active_interrupt==IRQ).
- pending  out  1  any unserviced request present (RST, NMI, or unmasked IRQ).
- busy  out  1  active_interrupt != NONE.

Behaviour:
- Reset (rst low, async):
  - active_interrupt=NONE, vector=16'hFFFC, irq_src=0, busy=0.
  - nmi_pend=0, sync flops=0, nmi_prev=0.
  - rst_pend=1, so pending=1 immediately after reset.
- Synchronisation: nmi and each irq bit pass through SYNC_STAGES flops before use. Latency from pin to pending is SYNC_STAGES+1 cycles for NMI and SYNC_STAGES for IRQ.
- NMI capture:
  - A rising edge of synchronised nmi (sync=1, nmi_prev=0) sets nmi_pend.
  - A held-high nmi produces exactly one request.
  - A new edge arriving while an NMI is active sets nmi_pend again, so it is serviced once more.
- IRQ qualification: req[k] = irq_sync[k] & irq_en[k] & ~statusReg[2]. IRQs are level-sensitive and not latched; dropping the line before arbitration loses the request.
- State machine:
  - IDLE: arbitration occurs when T1now & RDY & ~busy. Priority is rst_pend > nmi_pend > |req > brk.
    - Winner RST clears rst_pend.
    - Winner NMI clears nmi_pend.
    - Winner IRQ latches irq_src = lowest-index set req bit.
    - brk is considered only if none of the others is present.
    - If nothing is pending, stay IDLE.
    - Outputs update on the same posedge that performs arbitration (1-cycle latency from T1now).
  - ACTIVE: active_interrupt, vector and irq_src are frozen. New requests accumulate but do not preempt.
    - int_done & RDY: return to IDLE with active_interrupt=NONE and vector=16'hFFFC.
    - int_done while RDY low: ignored; the FSM must re-pulse it.
- Simultaneous events:
  - T1now coinciding with a new NMI edge: the edge is visible only if already latched into nmi_pend on an earlier cycle; otherwise it is serviced at the next T1now.
  - int_done and T1now in the same cycle: the clear takes effect; no arbitration that cycle.
- Vectors:
  - NMI = 16'hFFFA.
  - RST = 16'hFFFC.
  - IRQ and BRK = 16'hFFFE.
- pending is combinational: rst_pend | nmi_pend | (|req).
- rst asserted mid-ACTIVE: returns immediately to the reset values above.

Optional Feature:
- Macro INT_VECTOR_TABLE_EN.
- Defined: IRQ vector = 16'hFFFE - 2*(irq_src+1)*16'h0010, i.e. channel 0 = 16'hFFDE and channel 1 = 16'hFFBE. This gives per-channel handlers. BRK stays 16'hFFFE.
- Undefined: all IRQ channels use 16'hFFFE, which is 6502-compatible.

Test Plan:
- Release rst, pulse T1now with RDY=1 -> active_interrupt=1 (RST), vector=FFFC; int_done -> active_interrupt=0, pending=0.
- nmi held high for 10 cycles, T1now twice with int_done in between -> exactly one NMI (code 2, vector FFFA); second T1now yields NONE.
- irq=4'b1010, irq_en=4'b1111, statusReg=8'h00, T1now -> code 3, irq_src=1, vector FFFE; repeat with statusReg=8'h04 -> NONE, pending=0.
- NMI edge plus irq[0] plus brk, all pending at one T1now -> NMI first; after int_done and next T1now -> IRQ src 0; brk is not taken while the IRQ is present.
- RDY=0 during T1now and during int_done -> no state change; RDY=1 on the repeat -> normal arbitration and clear.
- With INT_VECTOR_TABLE_EN: irq[1] only -> vector FFBE; BRK alone -> vector FFFE.
